// File: rtl/shift_add_mult_seq_if.sv
// Operand/result handshake and accumulator drive bundle for the shift-add multiply sequencer.
interface shift_add_mult_seq_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           flush;
  logic           acc_load;
  logic           acc_en;
  logic [2*N-1:0] acc_data;
  logic           res_valid;
  logic           res_ready;
  logic           busy;

  modport master (
    output in_valid, a_in, b_in, flush, res_ready,
    input  in_ready, acc_load, acc_en, acc_data, res_valid, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, flush, res_ready,
    output in_ready, acc_load, acc_en, acc_data, res_valid, busy
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequences one partial product per cycle (multiplier MSB first) into a 2N-bit shift accumulator,
// then holds the accumulator while offering the product over a result handshake.
module shift_add_mult_seq #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input logic                clk,
  input logic                rst_n,
  shift_add_mult_seq_if.slave bus_if
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;

  logic           in_run;
  logic           in_done;
  logic           accept;
  logic           last_step;
  logic [CW-1:0]  bit_idx;

  assign in_run    = (state_q == RUN);
  assign in_done   = (state_q == DONE);
  assign last_step = (count_q == CW'(N-1));
  assign bit_idx   = CW'(N-1) - count_q;

  // In DONE a new pair may only enter alongside the consumer taking the product.
  assign bus_if.in_ready = (state_q == IDLE) || (in_done && bus_if.res_ready);
  assign accept          = bus_if.in_valid && bus_if.in_ready && !bus_if.flush;

  assign bus_if.busy      = in_run || in_done;
  assign bus_if.res_valid = in_done && !bus_if.flush;
  assign bus_if.acc_load  = in_run && (count_q == '0) && !bus_if.flush;
  assign bus_if.acc_en    = in_run && (count_q != '0) && !bus_if.flush;
  assign bus_if.acc_data  = (in_run && b_q[bit_idx]) ? {{N{1'b0}}, a_q} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (bus_if.flush) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus_if.a_in;
            b_q     <= bus_if.b_in;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (last_step) begin
            count_q <= '0;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          if (bus_if.res_ready) begin
            if (accept) begin
              a_q     <= bus_if.a_in;
              b_q     <= bus_if.b_in;
              count_q <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_add_mult_seq.md
Name: shift_add_mult_seq

Overview:
- Upstream sequencer for the shift accumulator (instantiated there with WIDTH = 2*N).
- Accepts an unsigned N-bit operand pair over a valid/ready handshake.
- Drives the accumulator's load/en/data_in with one partial product per cycle, multiplier MSB first, so the accumulator ends holding A*B.
- Then presents a result-valid handshake to the consumer and freezes the accumulator until the result is accepted.

Parameters:
- N, 8, operand width in bits; legal range N >= 2.
- CW, $clog2(N), step counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  sequencer can accept operands this cycle.
- a_in  input  N  multiplicand, unsigned.
- b_in  input  N  multiplier, unsigned.
- flush  input  1  synchronous abort; returns to IDLE.
- acc_load  output  1  to accumulator load.
- acc_en  output  1  to accumulator en.
- acc_data  output  2N  to accumulator data_in; partial product, zero-extended.
- res_valid  output  1  accumulator holds final product.
- res_ready  input  1  consumer accepts the product.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- Reset values: state = IDLE, count = 0, a_reg = 0, b_reg = 0.
- Outputs during reset: in_ready = 1; acc_load, acc_en, res_valid and busy = 0; acc_data = 0.
- Output timing: acc_* outputs are combinational decodes of registered state (state, count, a_reg, b_reg). The accumulator samples them at the edge that ends the cycle.

States:
- IDLE: in_ready = 1; acc_load = acc_en = 0; acc_data = 0.
  - On in_valid && in_ready: latch a_reg = a_in, b_reg = b_in, count = 0; go to RUN.
- RUN (count = k, 0 <= k <= N-1):
  - acc_data = b_reg[N-1-k] ? {N'b0, a_reg} : 0.
  - acc_load = (k == 0); acc_en = (k != 0). The two are never high together.
  - count increments each cycle. At k = N-1, go to DONE and reset count to 0.
  - in_ready = 0.
- DONE: res_valid = 1; acc_load = acc_en = 0, so the accumulator holds its value.
  - res_valid stays high until res_ready; the accumulator must not change while it waits.
  - On res_ready with in_valid: accept new operands in the same cycle (in_ready = res_ready in DONE) and go directly to RUN.
  - On res_ready without in_valid: go to IDLE.

Timing and arithmetic:
- Latency: from the accept edge, res_valid rises exactly N cycles later.
- Throughput: back-to-back, one product every N+1 cycles.
- Accumulator result: sum over k of pp_k * 2^(N-1-k) = A*B, max (2^N - 1)^2, which fits in 2N bits with no overflow.
- acc_data upper N bits are always 0.

Boundary conditions:
- Operand b = 0: the sequence still runs all N cycles. The first cycle loads 0, so no stale accumulator value survives; result 0.
- Operand a = 0: all partial products 0; result 0.
- in_valid during RUN: ignored, because in_ready = 0. The operands must be held by the source.
- in_valid in DONE while res_ready = 0: not accepted.
- flush (highest priority after reset), in any state:
  - next state IDLE, count = 0; the accept is suppressed that cycle.
  - acc_load and acc_en forced to 0 combinationally in the flush cycle.
  - res_valid forced to 0 in the flush cycle.
- Reset mid-RUN or mid-DONE: immediately returns to the reset values; no res_valid is produced for the aborted operation.

Test Plan:
- N = 8, a = 13, b = 11, res_ready = 1:
  - acc_load high in cycle 0 only; acc_en high in cycles 1..7.
  - acc_data nonzero only in the cycles where b bit 3, bit 1 and bit 0 are decoded (k = 4, 6, 7).
  - res_valid appears 8 cycles after accept; accumulator = 143.
- a = 255, b = 255: accumulator = 65025. a = 0, b = 200 and a = 77, b = 0: result 0; still N cycles; cycle 0 asserts acc_load.
- Back-to-back: in_valid held high with the pairs (3, 5) then (200, 100), res_ready = 1.
  - The second pair is accepted in the DONE cycle.
  - Results 15 and 20000, 9 cycles apart.
- Backpressure: res_ready = 0 for 5 cycles in DONE.
  - res_valid, acc_load = 0 and acc_en = 0 held throughout; accumulator stable at the product; in_ready = 0.
  - Product accepted when res_ready rises.
- flush at k = 3 of (9, 9):
  - Next cycle IDLE, in_ready = 1; no res_valid.
  - A following op (6, 7) yields 42.
- rst_n low asynchronously mid-RUN:
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, the op (2, 2) yields 4.
